cnn_residual_add_align: RTL

CNN_RESIDUAL_ADD_ALIGN -- requirements
Module: cnn_residual_add_align

---
 rtl/cnn_pkg.sv | 32 +++
 rtl/cnn_sync_fifo.sv | 71 +++++++
 rtl/cnn_residual_add_align.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// Shared definitions for the residual-add block: FSM states, clog2 and saturation limits.
package cnn_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain
    } state_e;

    localparam int unsigned MaxDw = 64;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res = 0;
        int unsigned v;
        v = (value > 0) ? value - 1 : 0;
        while (v != 0) begin
            v = v >> 1;
            res++;
        end
        return res;
    endfunction

    // Limits are produced at MaxDw bits; callers truncate to their own width.
    function automatic logic signed [MaxDw-1:0] sat_max(input int unsigned dw);
        return (64'sd1 << (dw - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [MaxDw-1:0] sat_min(input int unsigned dw);
        return -(64'sd1 << (dw - 1));
    endfunction

endpackage

// File: rtl/cnn_sync_fifo.sv
// Single-clock FIFO with same-edge push/pop; storage is not reset, only pointers and count.
module cnn_sync_fifo
    import cnn_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 1024
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     push_i,
    input  logic [DATA_WIDTH-1:0]    data_i,
    input  logic                     pop_i,
    output logic [DATA_WIDTH-1:0]    data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [clog2(DEPTH):0]    count_o
);

    localparam int unsigned AddrW = clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AddrW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AddrW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [AddrW:0]        count_q, count_d;
    logic                  do_push, do_pop;

    assign full_o  = (count_q == (AddrW + 1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    // A full FIFO still accepts a push when the same edge frees a slot.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AddrW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AddrW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + (AddrW + 1)'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - (AddrW + 1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i && do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/cnn_residual_add_align.sv
// Aligns main and shortcut pixel streams through per-branch FIFOs, adds with saturation and
// optional ReLU, and tracks frame boundaries on the output side.
module cnn_residual_add_align
    import cnn_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned IMAGE_WIDTH  = 16,
    parameter int unsigned IMAGE_HEIGHT = 16,
    parameter int unsigned CHANNEL_NUM  = 256,
    parameter int unsigned FIFO_DEPTH   = 1024
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          valid_in_no1,
    input  logic [DATA_WIDTH-1:0]         in_no1,
    input  logic                          valid_in_no2,
    input  logic [DATA_WIDTH-1:0]         in_no2,
    input  logic                          relu_en,
    output logic [DATA_WIDTH-1:0]         out,
    output logic                          valid_out,
    output logic                          sat,
    output logic                          frame_done,
    output logic                          ovf_no1,
    output logic                          ovf_no2,
    output logic [clog2(FIFO_DEPTH):0]    occ_no1,
    output logic [clog2(FIFO_DEPTH):0]    occ_no2
);

    localparam int unsigned FramePixels = IMAGE_WIDTH * IMAGE_HEIGHT * CHANNEL_NUM;
    localparam int unsigned FrameW      = clog2(FramePixels) + 1;
    localparam logic [FrameW-1:0] LastPix = FrameW'(FramePixels - 1);
    localparam logic signed [DATA_WIDTH:0] SatMax = (DATA_WIDTH + 1)'(sat_max(DATA_WIDTH));
    localparam logic signed [DATA_WIDTH:0] SatMin = (DATA_WIDTH + 1)'(sat_min(DATA_WIDTH));

    logic [DATA_WIDTH-1:0] data1, data2;
    logic                  full1, full2, empty1, empty2;
    logic                  pop;

    logic signed [DATA_WIDTH:0] sum, clamped;
    logic                       clamp_hit;
    logic [DATA_WIDTH-1:0]      res;

    logic [DATA_WIDTH-1:0] out_q;
    logic                  valid_q, sat_q, frame_done_q, ovf1_q, ovf2_q;
    logic [FrameW-1:0]     out_cnt_q, out_cnt_d;
    logic [FrameW-1:0]     in1_cnt_q, in1_cnt_d, in2_cnt_q, in2_cnt_d;
    logic                  frame_last, in1_last, in2_last;
    state_e                state_q, state_d;

    cnn_sync_fifo #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (FIFO_DEPTH)
    ) u_fifo_no1 (
        .clk_i  (clk),
        .reset_i(reset),
        .push_i (valid_in_no1),
        .data_i (in_no1),
        .pop_i  (pop),
        .data_o (data1),
        .full_o (full1),
        .empty_o(empty1),
        .count_o(occ_no1)
    );

    cnn_sync_fifo #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (FIFO_DEPTH)
    ) u_fifo_no2 (
        .clk_i  (clk),
        .reset_i(reset),
        .push_i (valid_in_no2),
        .data_i (in_no2),
        .pop_i  (pop),
        .data_o (data2),
        .full_o (full2),
        .empty_o(empty2),
        .count_o(occ_no2)
    );

    assign pop = !empty1 && !empty2;
    assign sum = $signed({data1[DATA_WIDTH-1], data1}) + $signed({data2[DATA_WIDTH-1], data2});

    always_comb begin
        clamped   = sum;
        clamp_hit = 1'b0;
        if (sum > SatMax) begin
            clamped   = SatMax;
            clamp_hit = 1'b1;
        end else if (sum < SatMin) begin
            clamped   = SatMin;
            clamp_hit = 1'b1;
        end
        res = clamped[DATA_WIDTH-1:0];
        if (relu_en && clamped[DATA_WIDTH]) begin
            res = '0;
        end
    end

    always_comb begin
        frame_last = pop && (out_cnt_q == LastPix);
        in1_last   = valid_in_no1 && (in1_cnt_q == LastPix);
        in2_last   = valid_in_no2 && (in2_cnt_q == LastPix);
        out_cnt_d  = out_cnt_q;
        in1_cnt_d  = in1_cnt_q;
        in2_cnt_d  = in2_cnt_q;
        if (pop) begin
            out_cnt_d = frame_last ? '0 : out_cnt_q + FrameW'(1);
        end
        if (valid_in_no1) begin
            in1_cnt_d = in1_last ? '0 : in1_cnt_q + FrameW'(1);
        end
        if (valid_in_no2) begin
            in2_cnt_d = in2_last ? '0 : in2_cnt_q + FrameW'(1);
        end

        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (valid_in_no1 || valid_in_no2 || !empty1 || !empty2) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (frame_last) begin
                    state_d = StIdle;
                end else if (in1_last || in2_last) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (frame_last) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q        <= '0;
            valid_q      <= 1'b0;
            sat_q        <= 1'b0;
            frame_done_q <= 1'b0;
            ovf1_q       <= 1'b0;
            ovf2_q       <= 1'b0;
            out_cnt_q    <= '0;
            in1_cnt_q    <= '0;
            in2_cnt_q    <= '0;
            state_q      <= StIdle;
        end else begin
            if (pop) begin
                out_q <= res;
            end
            valid_q      <= pop;
            sat_q        <= pop && clamp_hit;
            frame_done_q <= frame_last;
            ovf1_q       <= ovf1_q || (valid_in_no1 && full1 && !pop);
            ovf2_q       <= ovf2_q || (valid_in_no2 && full2 && !pop);
            out_cnt_q    <= out_cnt_d;
            in1_cnt_q    <= in1_cnt_d;
            in2_cnt_q    <= in2_cnt_d;
            state_q      <= state_d;
        end
    end

    assign out        = out_q;
    assign valid_out  = valid_q;
    assign sat        = sat_q;
    assign frame_done = frame_done_q;
    assign ovf_no1    = ovf1_q;
    assign ovf_no2    = ovf2_q;

endmodule
